// File: rtl/adder_error_accumulator.sv
// rtl/adder_error_accumulator.sv - error statistics for an approximate adder vs an exact reference
//
// Purpose: accepts {approx, exact} sum/carry pairs over a programmed run and accumulates
// the count of mismatching samples, the saturating sum of error distances (ED), the
// largest ED and the count of samples whose exact value is zero.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   start, num_samples        run request and run length (latched on accepted start)
//   in_valid, in_ready        sample handshake; a transfer is in_valid && in_ready
//   approx_sum/co, exact_sum/co  sample under test and its reference
//   busy, done                run in progress / results valid and stable
//   err_count, ed_sum, max_ed, zero_exact_count, sample_count  run results
module adder_error_accumulator #(
    parameter int N             = 16,
    parameter int INCLUDE_CARRY = 0,
    parameter int SAMPLE_W      = 24,
    parameter int ACC_W         = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SAMPLE_W-1:0] num_samples,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        approx_sum,
    input  logic                approx_co,
    input  logic [N-1:0]        exact_sum,
    input  logic                exact_co,
    output logic                busy,
    output logic                done,
    output logic [SAMPLE_W-1:0] err_count,
    output logic [ACC_W-1:0]    ed_sum,
    output logic [N:0]          max_ed,
    output logic [SAMPLE_W-1:0] zero_exact_count,
    output logic [SAMPLE_W-1:0] sample_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [SAMPLE_W-1:0] num_q, num_d;
    logic [SAMPLE_W-1:0] sample_count_q, sample_count_d;
    logic [SAMPLE_W-1:0] err_count_q, err_count_d;
    logic [SAMPLE_W-1:0] zero_count_q, zero_count_d;
    logic [ACC_W-1:0]    ed_sum_q, ed_sum_d;
    logic [N:0]          max_ed_q, max_ed_d;

    // S1: per-sample ED and flags; S2: same data one cycle later, feeding the accumulators
    logic                s1_valid_q, s1_valid_d;
    logic [N:0]          s1_ed_q, s1_ed_d;
    logic                s1_neq_q, s1_neq_d;
    logic                s1_zero_q, s1_zero_d;
    logic                s2_valid_q, s2_valid_d;
    logic [N:0]          s2_ed_q, s2_ed_d;
    logic                s2_neq_q, s2_neq_d;
    logic                s2_zero_q, s2_zero_d;

    logic [N:0]          a_val, e_val;
    logic [ACC_W:0]      ed_sum_ext;
    logic                xfer;

    assign in_ready = (state_q == ST_RUN) && (sample_count_q < num_q);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        a_val = (INCLUDE_CARRY != 0) ? {approx_co, approx_sum} : {1'b0, approx_sum};
        e_val = (INCLUDE_CARRY != 0) ? {exact_co, exact_sum}   : {1'b0, exact_sum};
    end

    // One extra bit catches the carry out of the accumulator so it can clamp instead of wrap
    assign ed_sum_ext = {1'b0, ed_sum_q} + (ACC_W+1)'(s2_ed_q);

    always_comb begin
        state_d        = state_q;
        num_d          = num_q;
        sample_count_d = sample_count_q;
        err_count_d    = err_count_q;
        zero_count_d   = zero_count_q;
        ed_sum_d       = ed_sum_q;
        max_ed_d       = max_ed_q;

        s1_valid_d = xfer;
        s1_ed_d    = (a_val >= e_val) ? (a_val - e_val) : (e_val - a_val);
        s1_neq_d   = (a_val != e_val);
        s1_zero_d  = (e_val == '0);
        s2_valid_d = s1_valid_q;
        s2_ed_d    = s1_ed_q;
        s2_neq_d   = s1_neq_q;
        s2_zero_d  = s1_zero_q;

        if (xfer) begin
            sample_count_d = sample_count_q + SAMPLE_W'(1);
        end

        if (s2_valid_q) begin
            if (s2_neq_q)  err_count_d  = err_count_q + SAMPLE_W'(1);
            if (s2_zero_q) zero_count_d = zero_count_q + SAMPLE_W'(1);
            ed_sum_d = ed_sum_ext[ACC_W] ? '1 : ed_sum_ext[ACC_W-1:0];
            if (s2_ed_q > max_ed_q) max_ed_d = s2_ed_q;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // Pipeline is empty here, so clearing cannot collide with an accumulate
                if (start) begin
                    num_d          = num_samples;
                    sample_count_d = '0;
                    err_count_d    = '0;
                    zero_count_d   = '0;
                    ed_sum_d       = '0;
                    max_ed_d       = '0;
                    state_d        = (num_samples == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer && (sample_count_q + SAMPLE_W'(1) == num_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            num_q          <= '0;
            sample_count_q <= '0;
            err_count_q    <= '0;
            zero_count_q   <= '0;
            ed_sum_q       <= '0;
            max_ed_q       <= '0;
            s1_valid_q     <= 1'b0;
            s1_ed_q        <= '0;
            s1_neq_q       <= 1'b0;
            s1_zero_q      <= 1'b0;
            s2_valid_q     <= 1'b0;
            s2_ed_q        <= '0;
            s2_neq_q       <= 1'b0;
            s2_zero_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            num_q          <= num_d;
            sample_count_q <= sample_count_d;
            err_count_q    <= err_count_d;
            zero_count_q   <= zero_count_d;
            ed_sum_q       <= ed_sum_d;
            max_ed_q       <= max_ed_d;
            s1_valid_q     <= s1_valid_d;
            s1_ed_q        <= s1_ed_d;
            s1_neq_q       <= s1_neq_d;
            s1_zero_q      <= s1_zero_d;
            s2_valid_q     <= s2_valid_d;
            s2_ed_q        <= s2_ed_d;
            s2_neq_q       <= s2_neq_d;
            s2_zero_q      <= s2_zero_d;
        end
    end

    assign busy             = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done             = (state_q == ST_DONE);
    assign err_count        = err_count_q;
    assign ed_sum           = ed_sum_q;
    assign max_ed           = max_ed_q;
    assign zero_exact_count = zero_count_q;
    assign sample_count     = sample_count_q;

endmodule

// File: tb/tb_adder_error_accumulator.sv
// tb/tb_adder_error_accumulator.sv - directed vector bench for adder_error_accumulator
module tb_adder_error_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] num_samples;
    logic        in_valid;
    logic [15:0] approx_sum, exact_sum;
    logic        approx_co, exact_co;

    logic        in_ready0, busy0, done0;
    logic [23:0] err0, zero0, cnt0;
    logic [39:0] ed0;
    logic [16:0] max0;

    logic        in_ready1, busy1, done1;
    logic [23:0] err1, zero1, cnt1;
    logic [39:0] ed1;
    logic [16:0] max1;

    logic        in_ready2, busy2, done2;
    logic [23:0] err2, zero2, cnt2;
    logic [16:0] ed2;
    logic [16:0] max2;

    always #5 clk = ~clk;

    adder_error_accumulator #(.N(16), .INCLUDE_CARRY(0), .SAMPLE_W(24), .ACC_W(40)) dut0 (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready0),
        .approx_sum(approx_sum), .approx_co(approx_co),
        .exact_sum(exact_sum), .exact_co(exact_co),
        .busy(busy0), .done(done0), .err_count(err0), .ed_sum(ed0), .max_ed(max0),
        .zero_exact_count(zero0), .sample_count(cnt0));

    adder_error_accumulator #(.N(16), .INCLUDE_CARRY(1), .SAMPLE_W(24), .ACC_W(40)) dut1 (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready1),
        .approx_sum(approx_sum), .approx_co(approx_co),
        .exact_sum(exact_sum), .exact_co(exact_co),
        .busy(busy1), .done(done1), .err_count(err1), .ed_sum(ed1), .max_ed(max1),
        .zero_exact_count(zero1), .sample_count(cnt1));

    adder_error_accumulator #(.N(16), .INCLUDE_CARRY(0), .SAMPLE_W(24), .ACC_W(17)) dut2 (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready2),
        .approx_sum(approx_sum), .approx_co(approx_co),
        .exact_sum(exact_sum), .exact_co(exact_co),
        .busy(busy2), .done(done2), .err_count(err2), .ed_sum(ed2), .max_ed(max2),
        .zero_exact_count(zero2), .sample_count(cnt2));

    typedef struct {
        logic [23:0]       num;
        logic [3:0][15:0]  ap;
        logic [3:0]        ac;
        logic [3:0][15:0]  ex;
        logic [3:0]        ec;
        logic [23:0]       e_err0, e_zero0, e_cnt;
        logic [39:0]       e_ed0;
        logic [16:0]       e_max0;
        logic [23:0]       e_err1, e_zero1;
        logic [39:0]       e_ed1;
        logic [16:0]       e_max1;
        logic [16:0]       e_ed2;
    } vec_t;

    vec_t vecs[5];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [23:0] n);
        start       = 1'b1;
        num_samples = n;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input logic [15:0] ap, input logic ac, input logic [15:0] ex, input logic ec);
        int guard;
        approx_sum = ap; approx_co = ac;
        exact_sum  = ex; exact_co  = ec;
        in_valid   = 1'b1;
        guard = 0;
        while (!in_ready0 && guard < 20) begin
            step();
            guard++;
        end
        chk("ready_wait", (guard < 20), 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (!done0 && guard < 20) begin
            step();
            guard++;
        end
        chk("done_wait", (guard < 20), 1);
    endtask

    task automatic set_samp(input int v, input int k, input logic [15:0] ap, input logic ac,
                            input logic [15:0] ex, input logic ec);
        vecs[v].ap[k] = ap; vecs[v].ac[k] = ac;
        vecs[v].ex[k] = ex; vecs[v].ec[k] = ec;
    endtask

    task automatic set_exp(input int v, input logic [23:0] er0, input logic [39:0] d0,
                           input logic [16:0] m0, input logic [23:0] z0, input logic [23:0] c,
                           input logic [23:0] er1, input logic [39:0] d1, input logic [16:0] m1,
                           input logic [23:0] z1, input logic [16:0] d2);
        vecs[v].e_err0 = er0; vecs[v].e_ed0 = d0; vecs[v].e_max0 = m0;
        vecs[v].e_zero0 = z0; vecs[v].e_cnt = c;
        vecs[v].e_err1 = er1; vecs[v].e_ed1 = d1; vecs[v].e_max1 = m1;
        vecs[v].e_zero1 = z1; vecs[v].e_ed2 = d2;
    endtask

    task automatic run_vec(input int v);
        do_start(vecs[v].num);
        for (int k = 0; k < int'(vecs[v].num); k++) begin
            if (k == 1) begin
                in_valid = 1'b0;
                step();
            end
            feed(vecs[v].ap[k], vecs[v].ac[k], vecs[v].ex[k], vecs[v].ec[k]);
        end
        wait_done();
        chk($sformatf("v%0d_err0", v),  err0,  vecs[v].e_err0);
        chk($sformatf("v%0d_ed0", v),   ed0,   vecs[v].e_ed0);
        chk($sformatf("v%0d_max0", v),  max0,  vecs[v].e_max0);
        chk($sformatf("v%0d_zero0", v), zero0, vecs[v].e_zero0);
        chk($sformatf("v%0d_cnt0", v),  cnt0,  vecs[v].e_cnt);
        chk($sformatf("v%0d_err1", v),  err1,  vecs[v].e_err1);
        chk($sformatf("v%0d_ed1", v),   ed1,   vecs[v].e_ed1);
        chk($sformatf("v%0d_max1", v),  max1,  vecs[v].e_max1);
        chk($sformatf("v%0d_zero1", v), zero1, vecs[v].e_zero1);
        chk($sformatf("v%0d_ed2", v),   ed2,   vecs[v].e_ed2);
        chk($sformatf("v%0d_busy", v),  busy0, 0);
    endtask

    initial begin
        int xfers, last_edge;
        logic done_at3, done_at4;

        // Exact stream
        vecs[0].num = 24'd4;
        for (int k = 0; k < 4; k++) set_samp(0, k, 16'h1234, 1'b0, 16'h1234, 1'b0);
        set_exp(0, 0, 0, 0, 0, 4,  0, 0, 0, 0,  0);
        // Mixed errors
        vecs[1].num = 24'd3;
        set_samp(1, 0, 16'h0010, 1'b0, 16'h0008, 1'b0);
        set_samp(1, 1, 16'h0000, 1'b0, 16'h0000, 1'b0);
        set_samp(1, 2, 16'hFFF0, 1'b0, 16'hFFFF, 1'b0);
        set_exp(1, 2, 23, 15, 1, 3,  2, 23, 15, 1,  23);
        // Carry handling: E is zero only when the carry is excluded
        vecs[2].num = 24'd1;
        set_samp(2, 0, 16'hFFFF, 1'b0, 16'h0000, 1'b1);
        set_exp(2, 1, 40'hFFFF, 17'hFFFF, 1, 1,  1, 1, 1, 0,  17'hFFFF);
        // Saturation: 4 x 0xFFFF overflows a 17-bit accumulator
        vecs[3].num = 24'd4;
        for (int k = 0; k < 4; k++) set_samp(3, k, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
        set_exp(3, 4, 40'h3FFFC, 17'hFFFF, 4, 4,  4, 40'h3FFFC, 17'hFFFF, 4,  17'h1FFFF);
        // ED 5, 3, 0, 256
        vecs[4].num = 24'd4;
        set_samp(4, 0, 16'h000A, 1'b0, 16'h0005, 1'b0);
        set_samp(4, 1, 16'h0007, 1'b0, 16'h000A, 1'b0);
        set_samp(4, 2, 16'h0001, 1'b0, 16'h0001, 1'b0);
        set_samp(4, 3, 16'h0100, 1'b0, 16'h0000, 1'b0);
        set_exp(4, 3, 264, 256, 1, 4,  3, 264, 256, 1,  264);

        // Reset then idle with in_valid but no start
        rst = 1'b1; start = 1'b0; num_samples = 24'd5; in_valid = 1'b1;
        approx_sum = 16'h0001; approx_co = 1'b0; exact_sum = 16'h0002; exact_co = 1'b0;
        step(); step();
        rst = 1'b0;
        step(); step(); step();
        chk("idle_in_ready", in_ready0, 0);
        chk("idle_busy", busy0, 0);
        chk("idle_done", done0, 0);
        chk("idle_err", err0, 0);
        chk("idle_ed", ed0, 0);
        chk("idle_max", max0, 0);
        chk("idle_zero", zero0, 0);
        chk("idle_cnt", cnt0, 0);
        in_valid = 1'b0;

        for (int v = 0; v < 5; v++) run_vec(v);

        // Start from DONE clears results in the same cycle done falls
        do_start(24'd1);
        chk("restart_done", done0, 0);
        chk("restart_busy", busy0, 1);
        chk("restart_ed", ed0, 0);
        chk("restart_max", max0, 0);
        feed(16'h0003, 1'b0, 16'h0001, 1'b0);
        wait_done();
        chk("restart_ed_final", ed0, 2);

        // Handshake: 2 samples, in_valid held for 5 cycles
        do_start(24'd2);
        approx_sum = 16'h0005; exact_sum = 16'h0001; approx_co = 1'b0; exact_co = 1'b0;
        in_valid = 1'b1;
        xfers = 0; last_edge = -1; done_at3 = 1'b0; done_at4 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (in_valid && in_ready0) begin
                xfers++;
                last_edge = c;
            end
            step();
            if (c == 0) chk("hs_cnt_after_first", cnt0, 1);
            if (c == 3) done_at3 = done0;
            if (c == 4) done_at4 = done0;
        end
        in_valid = 1'b0;
        chk("hs_xfers", xfers, 2);
        chk("hs_last_edge", last_edge, 1);
        chk("hs_in_ready_after", in_ready0, 0);
        chk("hs_done_early", done_at3, 0);
        chk("hs_done_on_time", done_at4, 1);
        chk("hs_ed", ed0, 8);
        chk("hs_cnt", cnt0, 2);

        // Zero-length run
        do_start(24'd0);
        chk("zero_run_done", done0, 1);
        chk("zero_run_busy", busy0, 0);
        chk("zero_run_cnt", cnt0, 0);

        // Abort after 3 of 10 samples with samples still in flight
        do_start(24'd10);
        in_valid = 1'b1;
        approx_sum = 16'h0100; exact_sum = 16'h0000;
        step(); step(); step();
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
        chk("abort_in_ready", in_ready0, 0);
        chk("abort_cnt", cnt0, 0);
        chk("abort_ed", ed0, 0);
        chk("abort_err", err0, 0);
        step(); step(); step();
        chk("abort_ed_later", ed0, 0);
        chk("abort_max_later", max0, 0);
        run_vec(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
